// File: rtl/dtube_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan driver.
package dtube_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 2;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned DATA_W     = NUM_DIGITS * NIBBLE_W;
  localparam int unsigned SEG_W      = 8;

  // Segment codes, active-high, bit0..6 = a..g
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/dtube_hex2seg.sv
// Combinational hex nibble to 7-segment (a..g) decoder.
module dtube_hex2seg
  import dtube_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble_i,
  output logic [6:0]          seg_c_o
);

  always_comb begin
    seg_c_o = SEG_0;
    case (nibble_i)
      4'h0: seg_c_o = SEG_0;
      4'h1: seg_c_o = SEG_1;
      4'h2: seg_c_o = SEG_2;
      4'h3: seg_c_o = SEG_3;
      4'h4: seg_c_o = SEG_4;
      4'h5: seg_c_o = SEG_5;
      4'h6: seg_c_o = SEG_6;
      4'h7: seg_c_o = SEG_7;
      4'h8: seg_c_o = SEG_8;
      4'h9: seg_c_o = SEG_9;
      4'hA: seg_c_o = SEG_A;
      4'hB: seg_c_o = SEG_B;
      4'hC: seg_c_o = SEG_C;
      4'hD: seg_c_o = SEG_D;
      4'hE: seg_c_o = SEG_E;
      4'hF: seg_c_o = SEG_F;
      default: seg_c_o = SEG_0;
    endcase
  end

endmodule

// File: rtl/digital_tube_scan.sv
// Time-multiplexed 4-digit 7-segment driver with frame-synchronous data update.
// Define DTUBE_BLANK_LEADING_ZERO_EN to blank leading-zero digits (digit0 never blanked).
module digital_tube_scan
  import dtube_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                  I_sys_clk,
  input  logic                  I_rst,
  input  logic                  I_enable,
  input  logic                  I_load,
  input  logic [DATA_W-1:0]     I_disp_data,
  input  logic [NUM_DIGITS-1:0] I_dp,
  output logic [NUM_DIGITS-1:0] O_sel,
  output logic [SEG_W-1:0]      O_seg,
  output logic [DATA_W-1:0]     O_disp_data,
  output logic                  O_test_en,
  output logic                  O_frame_done
);

  localparam int unsigned PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(NUM_DIGITS - 1);

  state_e                state_q, state_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [DIGIT_W-1:0]    digit_q, digit_d;
  logic [DATA_W-1:0]     act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [DATA_W-1:0]     pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  wrap_d;

  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  test_en_q;
  logic                  frame_done_q;

  logic [NIBBLE_W-1:0]   nibble;
  logic [6:0]            seg7;
  logic                  blank;

  // Next-state: FSM, prescaler, digit counter, active/pending data
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    digit_d      = digit_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    wrap_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (I_load) begin
          act_data_d = I_disp_data;
          act_dp_d   = I_dp;
        end
        if (I_enable) begin
          state_d = SCAN;
          presc_d = '0;
          digit_d = '0;
        end
      end
      SCAN: begin
        if (!I_enable) begin
          state_d = IDLE;
          presc_d = '0;
          digit_d = '0;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          digit_d = digit_q + DIGIT_W'(1);
          if (digit_q == DIGIT_LAST) begin
            wrap_d = 1'b1;
            if (pend_valid_q) begin
              act_data_d   = pend_data_q;
              act_dp_d     = pend_dp_q;
              pend_valid_d = 1'b0;
            end
          end
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
        // A load coincident with the wrap lands here, after the swap, so it waits a frame
        if (I_load) begin
          pend_data_d  = I_disp_data;
          pend_dp_d    = I_dp;
          pend_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign nibble = act_data_d[{digit_d, 2'b00} +: NIBBLE_W];

  dtube_hex2seg u_hex2seg (
    .nibble_i (nibble),
    .seg_c_o  (seg7)
  );

`ifdef DTUBE_BLANK_LEADING_ZERO_EN
  logic [DATA_W-1:0] upper;
  assign upper = act_data_d >> {digit_d, 2'b00};
  assign blank = (digit_d != '0) && (upper == '0);
`else
  assign blank = 1'b0;
`endif

  // Outputs are derived from next-state so they line up with the state they describe
  always_comb begin
    sel_d = '0;
    seg_d = '0;
    if (state_d == SCAN) begin
      sel_d = NUM_DIGITS'(1) << digit_d;
      seg_d = {act_dp_d[digit_d], (blank ? 7'h00 : seg7)};
    end
  end

  always_ff @(posedge I_sys_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      digit_q      <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      sel_q        <= '0;
      seg_q        <= '0;
      test_en_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      digit_q      <= digit_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      test_en_q    <= (state_d == SCAN);
      frame_done_q <= wrap_d;
    end
  end

  assign O_sel        = sel_q;
  assign O_seg        = seg_q;
  assign O_disp_data  = act_data_q;
  assign O_test_en    = test_en_q;
  assign O_frame_done = frame_done_q;

endmodule
